approx_add_arbiter: RTL and testbench
=====================================

Name: approx_add_arbiter

Overview:
- Shares one pipelined truncated (approximate) adder among N_REQ requesters using round-robin arbitration.
- Each request carries its own precision, the number of kept MSBs (BIT_WIDTH). Operand bits below that are masked before the add, and the result's low bits are zero.
- Sits between DFG-scheduled add operations and the single physical approximate-adder resource.
- Returns the sum tagged with the requester ID through a valid/ready response port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand and result width.
- PREC_W, 6, width of each per-request precision field.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_a  in  N_REQ*DATA_W  operand A, requester i at slice [i*DATA_W +: DATA_W]
- req_b  in  N_REQ*DATA_W  operand B, same packing
- req_prec  in  N_REQ*PREC_W  kept MSB count, requester i at [i*PREC_W +: PREC_W]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accept
- rsp_id  out  clog2(N_REQ)  originating requester index
- rsp_sum  out  DATA_W  approximate sum
- ops_cnt  out  CNT_W  completed responses; wraps modulo 2^CNT_W

Behaviour:
- Reset: synchronous on posedge clk when rst_n=0. Clears all pipeline valids, so in-flight operations are dropped with no response. Also sets rsp_valid=0, rsp_id=0, rsp_sum=0, ops_cnt=0, rr pointer=0. req_ready is 0 while rst_n=0.
- Global enable: en = !s2_valid || rsp_ready. When en=0 the whole pipeline holds its state and no requester is granted.
- Arbitration (combinational):
  - Search from rr pointer upward, wrapping modulo N_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[i] = en && win[i], so at most one bit is set.
  - A handshake occurs when req_valid[i] && req_ready[i].
- Pointer update: only on a handshake, rr <= (granted index + 1) mod N_REQ. Otherwise rr holds.
- Precision decode:
  - p = req_prec slice; values 0 or > DATA_W are treated as DATA_W (exact add).
  - mask = all-ones shifted left by (DATA_W - p).
- Stage 1 (on en): s1_valid <= handshake; s1_a <= a & mask; s1_b <= b & mask; s1_id <= granted index.
- Stage 2 (on en): s2_valid <= s1_valid; s2_sum <= s1_a + s1_b, carry out discarded (mod 2^DATA_W); s2_id <= s1_id.
- Outputs: rsp_valid = s2_valid, rsp_sum = s2_sum, rsp_id = s2_id, all registered.
- Latency and throughput: a handshake in cycle t gives rsp_valid in cycle t+2 when not stalled. Throughput is 1 op/cycle.
- Bubbles: not collapsed. A stall freezes both stages, including an empty s1.
- ops_cnt increments by 1 on each rsp_valid && rsp_ready.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,N_REQ-1,0,...
- Operands are sampled only at the handshake. Requesters must hold a, b, prec and valid until req_ready. The block never drops an accepted request except on reset.

Test Plan:
- Single request, no stall: requester 2 sends a=0x00001234, b=0x00000FFF, prec=24. Required: req_ready[2]=1 in the same cycle; two cycles later rsp_valid=1, rsp_id=2, rsp_sum=0x00002100; ops_cnt=1 after accept.
- Exact and clamped precision: prec=32, then prec=0, then prec=40, each with a=0xFFFFFFFF, b=0x00000002. Required: rsp_sum=0x00000001 for all three (carry discarded).
- Heavy truncation: prec=1, a=0x80000000, b=0x7FFFFFFF. Required: rsp_sum=0x80000000.
- Round robin: all 4 requesters held valid for 8 cycles, rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0,1,2,3 with back-to-back rsp_valid; then deassert requester 1 and check the sequence skips ID 1 without a bubble.
- Backpressure: hold rsp_ready=0 for 3 cycles while a response is valid. Required: rsp_sum and rsp_id stable, req_ready all 0, rr unchanged, no loss or duplication after release, ops_cnt counts only accepted responses.
- Reset mid-operation: pull rst_n low one cycle after two handshakes. Required: next cycle rsp_valid=0, ops_cnt=0, no response ever emitted for those ops, and the first grant after release goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/approx_add_arbiter.sv
// Round-robin front end for one shared two-stage truncated adder.
// Each request keeps only its requested number of MSBs; the tagged sum returns on a valid/ready port.
module approx_add_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int PREC_W = 6,
    parameter int CNT_W  = 16,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    input  logic [N_REQ*PREC_W-1:0]   req_prec,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic [CNT_W-1:0]          ops_cnt
);

    logic [ID_W-1:0]     rr;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     next_rr;
    logic                found;
    logic                en;
    logic                handshake;
    logic [2*N_REQ-1:0]  valid_dbl;
    logic [N_REQ-1:0]    valid_rot;
    logic [PREC_W-1:0]   prec_sel;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;
    logic [DATA_W-1:0]   mask;

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_a;
    logic [DATA_W-1:0]   s1_b;
    logic [ID_W-1:0]     s1_id;
    logic                s2_valid;
    logic [DATA_W-1:0]   s2_sum;
    logic [ID_W-1:0]     s2_id;

    assign en = !s2_valid || rsp_ready;

    // Rotate the valids so the pointer sits at bit 0, pick the lowest set bit, then rotate back.
    always_comb begin
        int off;
        int gsum;
        off       = 0;
        gsum      = 0;
        found     = 1'b0;
        valid_dbl = {req_valid, req_valid};
        valid_rot = N_REQ'(valid_dbl >> rr);
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        gsum = int'(rr) + off;
        if (gsum >= N_REQ) begin
            gsum = gsum - N_REQ;
        end
        grant_id = ID_W'(gsum);
        next_rr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        prec_sel  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = rst_n && en && found && (grant_id == ID_W'(k));
            if (grant_id == ID_W'(k)) begin
                a_sel    = req_a[k*DATA_W +: DATA_W];
                b_sel    = req_b[k*DATA_W +: DATA_W];
                prec_sel = req_prec[k*PREC_W +: PREC_W];
            end
        end
    end

    assign handshake = |(req_valid & req_ready);

    // Zero or oversized precision means an exact add, so the mask is all ones.
    always_comb begin
        int keep;
        keep = int'(prec_sel);
        if (keep == 0 || keep > DATA_W) begin
            keep = DATA_W;
        end
        mask = {DATA_W{1'b1}} << (DATA_W - keep);
    end

    // Both stages advance together on en, so a stall also freezes an empty stage 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr       <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_id    <= '0;
            ops_cnt  <= '0;
        end else begin
            if (handshake) begin
                rr <= next_rr;
            end
            if (en) begin
                s1_valid <= handshake;
                s1_a     <= a_sel & mask;
                s1_b     <= b_sel & mask;
                s1_id    <= grant_id;
                s2_valid <= s1_valid;
                s2_sum   <= s1_a + s1_b;
                s2_id    <= s1_id;
            end
            if (s2_valid && rsp_ready) begin
                ops_cnt <= ops_cnt + 1'b1;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_sum   = s2_sum;
    assign rsp_id    = s2_id;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Directed bench for approx_add_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the named scenarios.
module tb_approx_add_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int CW = 16;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*DW-1:0]  req_a;
    logic [N*DW-1:0]  req_b;
    logic [N*PW-1:0]  req_prec;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [DW-1:0]    rsp_sum;
    logic [CW-1:0]    ops_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit modelOn = 0;

    typedef struct {
        int          id;
        logic [31:0] sum;
        int          at;
    } rsp_t;
    rsp_t rspLog[$];

    // Model state: two in-flight slots (slot 1 is the visible response), pointer and counter.
    bit          pv[2];
    int          pid[2];
    logic [31:0] psum[2];
    int          rrM = 0;
    int          cntM = 0;

    approx_add_arbiter #(.N_REQ(N), .DATA_W(DW), .PREC_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_prec  (req_prec),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .ops_cnt   (ops_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Keep the top p bits of each operand, add them as integers, shift back into place.
    function automatic logic [31:0] approx(input logic [31:0] a, input logic [31:0] b, input int p);
        int k;
        k = (p == 0 || p > 32) ? 32 : p;
        return ((a >> (32 - k)) + (b >> (32 - k))) << (32 - k);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b, input int p);
        req_a[i*DW +: DW]    = a;
        req_b[i*DW +: DW]    = b;
        req_prec[i*PW +: PW] = PW'(p);
    endtask

    task automatic doReset();
        rst_n = 0;
        step(2);
        rst_n = 1;
        rspLog.delete();
    endtask

    task automatic sendOne(input int i, input logic [31:0] a, input logic [31:0] b, input int p);
        bit got;
        got = 0;
        applyStimulus(i, a, b, p);
        req_valid[i] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: requester %0d never granted", i);
        end
        step(1);
        req_valid[i] = 1'b0;
    endtask

    task automatic expectRsp(input string name, input int id, input logic [31:0] sum, output int at);
        int w;
        rsp_t r;
        w  = 0;
        at = -1;
        while (rspLog.size() == 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (rspLog.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: no response, required id %0d sum %h", name, id, sum);
        end else begin
            r  = rspLog.pop_front();
            at = r.at;
            checkOutput({name, " id"}, 32'(r.id), 32'(id));
            checkOutput({name, " sum"}, r.sum, sum);
        end
    endtask

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        int          gi;
        bit          fnd;
        bit          enM;
        logic [3:0]  expReady;
        cyc++;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            rspLog.push_back('{int'(rsp_id), rsp_sum, cyc});
        end
        if (modelOn) begin
            enM = !pv[1] || rsp_ready;
            fnd = 0;
            gi  = 0;
            for (int k = 0; k < N; k++) begin
                if (!fnd && req_valid[(rrM + k) % N]) begin
                    fnd = 1;
                    gi  = (rrM + k) % N;
                end
            end
            expReady = (rst_n && enM && fnd) ? (4'b0001 << gi) : 4'b0000;
            checkOutput("model req_ready", 32'(req_ready), 32'(expReady));
            checkOutput("model rsp_valid", 32'(rsp_valid), 32'(pv[1]));
            if (pv[1]) begin
                checkOutput("model rsp_id", 32'(rsp_id), 32'(pid[1]));
                checkOutput("model rsp_sum", rsp_sum, psum[1]);
            end
            checkOutput("model ops_cnt", 32'(ops_cnt), 32'(cntM));
            if (!rst_n) begin
                pv[0] = 0; pv[1] = 0;
                rrM   = 0;
                cntM  = 0;
            end else begin
                if (pv[1] && rsp_ready) cntM = (cntM + 1) % (1 << CW);
                if (enM) begin
                    pv[1]   = pv[0];
                    pid[1]  = pid[0];
                    psum[1] = psum[0];
                    pv[0]   = fnd;
                    pid[0]  = gi;
                    psum[0] = approx(req_a[gi*DW +: DW], req_b[gi*DW +: DW], int'(req_prec[gi*PW +: PW]));
                    if (fnd) rrM = (gi + 1) % N;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run exceeded 100000 ns, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int at;
        int prevAt;
        int rrIds[14];
        logic [31:0] rrSum[4];
        rrIds = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
        rrSum = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404};

        rst_n     = 0;
        rsp_ready = 1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_prec  = '0;

        checkOutput("pin model prec24", approx(32'h0000_1234, 32'h0000_0FFF, 24), 32'h0000_2100);
        checkOutput("pin model prec0", approx(32'hFFFF_FFFF, 32'h0000_0002, 0), 32'h0000_0001);
        checkOutput("pin model prec40", approx(32'hFFFF_FFFF, 32'h0000_0002, 40), 32'h0000_0001);
        checkOutput("pin model prec1", approx(32'h8000_0000, 32'h7FFF_FFFF, 1), 32'h8000_0000);

        step(2);
        modelOn = 1;
        req_valid = 4'b1111;
        @(negedge clk);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset rsp_sum", rsp_sum, 32'd0);
        checkOutput("reset ops_cnt", 32'(ops_cnt), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        step(1);
        req_valid = '0;
        rst_n = 1;

        // Single request from requester 2
        applyStimulus(2, 32'h0000_1234, 32'h0000_0FFF, 24);
        req_valid[2] = 1'b1;
        @(negedge clk);
        checkOutput("single req_ready", 32'(req_ready), 32'h4);
        step(1);
        req_valid[2] = 1'b0;
        @(negedge clk);
        checkOutput("single latency early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("single rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("single rsp_id", 32'(rsp_id), 32'd2);
        checkOutput("single rsp_sum", rsp_sum, 32'h0000_2100);
        @(negedge clk);
        checkOutput("single ops_cnt", 32'(ops_cnt), 32'd1);
        step(1);
        rspLog.delete();

        // Exact, clamped and heavily truncated precision
        sendOne(0, 32'hFFFF_FFFF, 32'h0000_0002, 32);
        sendOne(0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        sendOne(0, 32'hFFFF_FFFF, 32'h0000_0002, 40);
        sendOne(0, 32'h8000_0000, 32'h7FFF_FFFF, 1);
        expectRsp("prec32", 0, 32'h0000_0001, at);
        expectRsp("prec0", 0, 32'h0000_0001, at);
        expectRsp("prec40", 0, 32'h0000_0001, at);
        expectRsp("prec1", 0, 32'h8000_0000, at);
        step(1);

        // Round robin with all valid, then with requester 1 dropped
        doReset();
        for (int i = 0; i < N; i++) applyStimulus(i, 32'h100 * (i + 1), 32'(i + 1), 32);
        req_valid = 4'b1111;
        step(8);
        req_valid[1] = 1'b0;
        step(6);
        req_valid = '0;
        prevAt = -1;
        for (int k = 0; k < 14; k++) begin
            expectRsp("round robin", rrIds[k], rrSum[rrIds[k]], at);
            if (k > 0 && at >= 0 && prevAt >= 0) checkOutput("round robin back-to-back", 32'(at - prevAt), 32'd1);
            prevAt = at;
        end
        step(1);

        // Backpressure with a response parked in the output stage
        doReset();
        rsp_ready = 0;
        applyStimulus(0, 32'h1111_0000, 32'h2222_0000, 16);
        applyStimulus(1, 32'h0000_ABCD, 32'h0000_1111, 32);
        applyStimulus(2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 8);
        req_valid = 4'b0011;
        step(1);
        req_valid[0] = 1'b0;
        step(1);
        req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall req_ready", 32'(req_ready), 32'd0);
            checkOutput("stall rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall rsp_id", 32'(rsp_id), 32'd0);
            checkOutput("stall rsp_sum", rsp_sum, 32'h3333_0000);
            checkOutput("stall ops_cnt", 32'(ops_cnt), 32'd0);
            step(1);
        end
        rsp_ready = 1;
        @(negedge clk);
        checkOutput("release grant keeps pointer", 32'(req_ready), 32'h4);
        step(1);
        req_valid[2] = 1'b0;
        @(negedge clk);
        checkOutput("release grant wraps", 32'(req_ready), 32'h1);
        step(1);
        req_valid = '0;
        expectRsp("bp first", 0, 32'h3333_0000, at);
        expectRsp("bp second", 1, 32'h0000_BCDE, at);
        expectRsp("bp third", 2, 32'hFF00_0000, at);
        expectRsp("bp fourth", 0, 32'h3333_0000, at);
        step(2);
        @(negedge clk);
        checkOutput("bp ops_cnt", 32'(ops_cnt), 32'd4);
        step(1);

        // Reset while two operations are in flight
        rsp_ready = 0;
        for (int i = 0; i < N; i++) applyStimulus(i, 32'h100 * (i + 1), 32'(i + 1), 32);
        req_valid = 4'b1111;
        step(2);
        rst_n = 0;
        @(negedge clk);
        checkOutput("in reset req_ready", 32'(req_ready), 32'd0);
        step(1);
        rst_n = 1;
        rsp_ready = 1;
        @(negedge clk);
        checkOutput("post reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("post reset ops_cnt", 32'(ops_cnt), 32'd0);
        checkOutput("post reset first grant", 32'(req_ready), 32'h1);
        checkOutput("post reset no stale rsp", 32'(rspLog.size()), 32'd0);
        step(1);
        req_valid = '0;
        expectRsp("post reset rsp", 0, 32'h0000_0101, at);
        step(4);
        checkOutput("post reset nothing extra", 32'(rspLog.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
